// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package fetch_unit_pkg;

  localparam int PC_WIDTH = 12;
  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 12'h000;
  localparam int INSN_WIDTH = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Two-entry instruction FIFO; entry 0 is always the head so the outputs come straight from flops.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [PC_W-1:0]       push_pc_i,
  input  logic [INSN_WIDTH-1:0] push_insn_i,
  output logic [1:0]            count_o,
  output logic [PC_W-1:0]       head_pc_o,
  output logic [INSN_WIDTH-1:0] head_insn_o
);

  logic [PC_W-1:0]       pc0_q, pc1_q;
  logic [INSN_WIDTH-1:0] insn0_q, insn1_q;
  logic [1:0]            count_q;

  // Storage and occupancy; flush wins over any push, a pop shifts entry 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      insn0_q <= '0;
      insn1_q <= '0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_q   <= push_pc_i;
            insn0_q <= push_insn_i;
          end else begin
            pc1_q   <= push_pc_i;
            insn1_q <= push_insn_i;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          pc0_q   <= pc1_q;
          insn0_q <= insn1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            pc0_q   <= pc1_q;
            insn0_q <= insn1_q;
            pc1_q   <= push_pc_i;
            insn1_q <= push_insn_i;
          end else begin
            pc0_q   <= push_pc_i;
            insn0_q <= push_insn_i;
          end
        end
        default: begin
          count_q <= count_q;
        end
      endcase
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc0_q;
  assign head_insn_o = insn0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues ROM reads, tracks the one-cycle return and buffers words for decode.
module fetch_unit #(
  parameter int PC_WIDTH = fetch_unit_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = fetch_unit_pkg::RESET_VECTOR
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                fetch_enable,
  output logic [PC_WIDTH-1:0]                 rom_address,
  input  logic [fetch_unit_pkg::INSN_WIDTH-1:0] rom_data,
  input  logic                                redirect_valid,
  input  logic [PC_WIDTH-1:0]                 redirect_pc,
  output logic                                insn_valid,
  input  logic                                insn_ready,
  output logic [fetch_unit_pkg::INSN_WIDTH-1:0] insn_data,
  output logic [PC_WIDTH-1:0]                 insn_pc
);
  import fetch_unit_pkg::INSN_WIDTH;
  import fetch_unit_pkg::PC_STEP;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          count_s;
  logic [2:0]          occupancy_s;
  logic                pop_s, issue_s, push_s;

  // Slots already committed must stay below the FIFO depth so every in-flight word has a home.
  always_comb begin
    pop_s       = insn_valid & insn_ready;
    occupancy_s = {1'b0, count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s     = fetch_enable & ~redirect_valid & (occupancy_s < 3'd2);
    push_s      = inflight_q & ~redirect_valid;
  end

  // Next fetch PC and in-flight tracking; a redirect discards whatever the ROM returns next.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
    end else if (issue_s) begin
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(PC_STEP);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buffer #(
    .PC_W(PC_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .flush_i    (redirect_valid),
    .push_pc_i  (inflight_pc_q),
    .push_insn_i(rom_data),
    .count_o    (count_s),
    .head_pc_o  (insn_pc),
    .head_insn_o(insn_data)
  );

  assign rom_address = fetch_pc_q;
  assign insn_valid  = (count_s != 2'd0);

endmodule
